// File: rtl/mux_pkg.sv
// Shared arbitration types and sizing helpers for the stream mux family.
package mux_pkg;

  typedef enum logic {
    ARB_RR,
    ARB_FIXED
  } arb_mode_t;

  // Channel-index width. It is never zero, so a single-channel build still
  // has a 1-bit select.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational arbiter. It returns a one-hot grant, the winning index and an
// any-request flag. In round-robin mode the scan starts at ptr.
module rr_picker
  import mux_pkg::*;
#(
  parameter int        N     = 4,
  parameter arb_mode_t MODE  = ARB_RR,
  parameter int        SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    shift;
  int unsigned    sum;

  // The request vector is doubled and shifted down by the start index.
  // Bit 0 of rot is then the first position to scan. The position of the
  // lowest set bit in rot is added back to the start index, modulo N.
  always_comb begin
    dbl       = {req, req};
    shift     = (MODE == ARB_RR) ? int'(ptr) : 0;
    rot       = N'(dbl >> shift);
    any       = 1'b0;
    sum       = 0;
    grant_idx = '0;
    for (int unsigned j = 0; j < int'(N); j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        sum = j + shift;
        if (sum >= int'(N)) sum = sum - int'(N);
        grant_idx = SEL_W'(sum);
      end
    end
  end

  // Build the one-hot grant from the winning index.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < int'(N); i++) begin
      grant[i] = any && (grant_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/rr_mux_stream.sv
// N-to-1 valid/ready stream mux with arbitration and a registered output
// stage. Each output word is tagged with the index of its source channel.
module rr_mux_stream
  import mux_pkg::*;
#(
  parameter int        N     = 4,
  parameter int        W     = 32,
  parameter arb_mode_t MODE  = ARB_RR,
  parameter int        SEL_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel
);

  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             any;
  logic             load;
  logic [W-1:0]     win_data;

  rr_picker #(
    .N    (N),
    .MODE (MODE),
    .SEL_W(SEL_W)
  ) u_picker (
    .req      (in_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (any)
  );

  // The output register can accept a word when it is empty or draining.
  always_comb begin
    load     = !out_valid || out_ready;
    in_ready = (rst && load) ? grant : '0;
  end

  // Select the data of the granted channel with an AND-OR mux.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < int'(N); i++) begin
      if (grant[i]) win_data = in_data[i*W +: W];
    end
  end

  // Output register and round-robin pointer.
  // The pointer moves only when a grant is made.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_sel   <= grant_idx;
        if (MODE == ARB_RR) begin
          ptr <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_stream.sv
// Testbench for rr_mux_stream. It runs directed scenarios and a randomized
// comparison against a simple arbitration model.
// Instances: N=4 round-robin, N=4 fixed priority, and N=3 round-robin.
module tb_rr_mux_stream;
  import mux_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   in_valid = '0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic [3:0]   ir_rr, ir_fx;
  logic         ov_rr, ov_fx;
  logic [31:0]  od_rr, od_fx;
  logic [1:0]   os_rr, os_fx;

  logic [2:0]   iv3 = '0;
  logic [95:0]  data3 = '0;
  logic         or3 = 1'b0;
  logic [2:0]   ir3;
  logic         ov3;
  logic [31:0]  od3;
  logic [1:0]   os3;

  int errors = 0;
  int checks = 0;

  // Model state, one entry per instance: 0 = rr4, 1 = fx4, 2 = rr3.
  int mv[3];
  int md[3];
  int ms[3];
  int mp[3];

  always #5 clk = ~clk;

  rr_mux_stream #(.N(4), .W(32), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_rr),
    .in_data(in_data), .out_valid(ov_rr), .out_ready(out_ready),
    .out_data(od_rr), .out_sel(os_rr));

  rr_mux_stream #(.N(4), .W(32), .MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_fx),
    .in_data(in_data), .out_valid(ov_fx), .out_ready(out_ready),
    .out_data(od_fx), .out_sel(os_fx));

  rr_mux_stream #(.N(3), .W(32), .MODE(ARB_RR)) dut_3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
    .in_data(data3), .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .out_sel(os3));

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_default_data;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'(i);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    iv3 = '0;
    or3 = 1'b0;
    set_default_data();
    repeat (2) tick();
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      mv[u] = 0; md[u] = 0; ms[u] = 0; mp[u] = 0;
    end
  endtask

  // Returns the winning channel, or -1 when no channel requests.
  function automatic int pick(input logic [3:0] v, input int n, input int p, input bit fixed);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = fixed ? k : (p + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (ov_rr !== 1'b0 || od_rr !== 32'd0 || os_rr !== 2'd0 || ir_rr !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h s=%0d r=%b, need 0/0/0/0", ov_rr, od_rr, os_rr, ir_rr);
    end
    rst = 1'b1;
    set_default_data();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ir_rr !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_ready: got %b need 0001", ir_rr);
    end
    tick();
    tick();
    checks++;
    if (ov_rr !== 1'b1 || os_rr !== 2'd1 || od_rr !== 32'd1) begin
      errors++;
      $display("FAIL reset_prestream: got v=%b s=%0d d=%h need 1/1/1", ov_rr, os_rr, od_rr);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ov_rr !== 1'b0 || od_rr !== 32'd0 || os_rr !== 2'd0 || ir_rr !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h s=%0d r=%b need 0/0/0/0", ov_rr, od_rr, os_rr, ir_rr);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (ov_rr !== 1'b1 || os_rr !== 2'd0) begin
      errors++;
      $display("FAIL reset_release_sel: got v=%b s=%0d need 1/0", ov_rr, os_rr);
    end
  endtask

  task automatic test_single;
    do_reset();
    in_valid = 4'b0100;
    in_data[2*32 +: 32] = 32'hDEAD_0002;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ir_rr !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b need 0100", ir_rr);
    end
    tick();
    checks++;
    if (ov_rr !== 1'b1 || od_rr !== 32'hDEAD_0002 || os_rr !== 2'd2) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h s=%0d need 1/dead0002/2", ov_rr, od_rr, os_rr);
    end
  endtask

  task automatic test_fairness;
    do_reset();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (ov_rr !== 1'b1 || os_rr !== 2'(k % 4) || od_rr !== 32'(k % 4)) begin
        errors++;
        $display("FAIL rr_fair[%0d]: got v=%b s=%0d d=%h need 1/%0d", k, ov_rr, os_rr, od_rr, k % 4);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (ir_rr !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b need 0000", k, ir_rr);
      end
      tick();
      checks++;
      if (ov_rr !== 1'b1 || os_rr !== 2'd1 || od_rr !== 32'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%h need 1/1/1", k, ov_rr, os_rr, od_rr);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (ov_rr !== 1'b1 || os_rr !== 2'd2) begin
      errors++;
      $display("FAIL bp_resume: got v=%b s=%0d need 1/2", ov_rr, os_rr);
    end
  endtask

  task automatic test_fixed_skip;
    logic [1:0] rr_exp [5];
    rr_exp = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
    do_reset();
    in_valid = 4'b1010;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (ir_fx !== 4'b0010) begin
        errors++;
        $display("FAIL fx_ready[%0d]: got %b need 0010", k, ir_fx);
      end
      tick();
      checks++;
      if (ov_fx !== 1'b1 || os_fx !== 2'd1) begin
        errors++;
        $display("FAIL fx_sel[%0d]: got v=%b s=%0d need 1/1", k, ov_fx, os_fx);
      end
      checks++;
      if (ov_rr !== 1'b1 || os_rr !== rr_exp[k]) begin
        errors++;
        $display("FAIL rr_skip[%0d]: got v=%b s=%0d need 1/%0d", k, ov_rr, os_rr, rr_exp[k]);
      end
    end
  endtask

  task automatic test_idle_wrap;
    do_reset();
    in_valid = 4'b1000;
    out_ready = 1'b1;
    tick();
    checks++;
    if (ov_rr !== 1'b1 || os_rr !== 2'd3) begin
      errors++;
      $display("FAIL wrap_grant3: got v=%b s=%0d need 1/3", ov_rr, os_rr);
    end
    in_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ov_rr !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid[%0d]: got %b need 0", k, ov_rr);
      end
    end
    in_valid = 4'b1001;
    tick();
    checks++;
    if (ov_rr !== 1'b1 || os_rr !== 2'd0) begin
      errors++;
      $display("FAIL wrap_first: got v=%b s=%0d need 1/0", ov_rr, os_rr);
    end
    tick();
    checks++;
    if (ov_rr !== 1'b1 || os_rr !== 2'd3) begin
      errors++;
      $display("FAIL wrap_second: got v=%b s=%0d need 1/3", ov_rr, os_rr);
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
      iv3 = 3'($urandom);
      or3 = ($urandom % 3) != 0;
      for (int i = 0; i < 3; i++) data3[i*32 +: 32] = $urandom;
      #1;
      for (int u = 0; u < 3; u++) begin
        int n, w, ld;
        logic [3:0] v, exp_ir, act_ir;
        logic rdy;
        n = (u == 2) ? 3 : 4;
        v = (u == 2) ? {1'b0, iv3} : in_valid;
        rdy = (u == 2) ? or3 : out_ready;
        ld = (mv[u] == 0 || rdy) ? 1 : 0;
        w = pick(v, n, mp[u], u == 1);
        exp_ir = (ld != 0 && w >= 0) ? 4'(1 << w) : 4'd0;
        case (u)
          0: act_ir = ir_rr;
          1: act_ir = ir_fx;
          default: act_ir = {1'b0, ir3};
        endcase
        checks++;
        if (act_ir !== exp_ir) begin
          errors++;
          $display("FAIL rand_ready u%0d c%0d: got %b need %b", u, c, act_ir, exp_ir);
        end
        if (ld != 0) begin
          if (w >= 0) begin
            mv[u] = 1;
            ms[u] = w;
            md[u] = (u == 2) ? int'(data3[w*32 +: 32]) : int'(in_data[w*32 +: 32]);
            if (u != 1) mp[u] = (w + 1) % n;
          end else begin
            mv[u] = 0;
          end
        end
      end
      tick();
      for (int u = 0; u < 3; u++) begin
        logic av;
        logic [31:0] ad;
        logic [1:0] as;
        case (u)
          0: begin av = ov_rr; ad = od_rr; as = os_rr; end
          1: begin av = ov_fx; ad = od_fx; as = os_fx; end
          default: begin av = ov3; ad = od3; as = os3; end
        endcase
        checks++;
        if (av !== 1'(mv[u]) || (mv[u] != 0 && (ad !== 32'(md[u]) || as !== 2'(ms[u])))) begin
          errors++;
          $display("FAIL rand_out u%0d c%0d: got v=%b d=%h s=%0d need v=%0d d=%h s=%0d",
                   u, c, av, ad, as, mv[u], 32'(md[u]), ms[u]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_fixed_skip();
    test_idle_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_stream.md
Name: rr_mux_stream

Overview:
- Parametrised successor to the fixed 32-way combinational mux.
- Selects one of N valid/ready input channels of W bits by arbitration rather than an external select.
- Drives a single registered valid/ready output stream, tagged with the winning channel index.
- Sits between multiple producers (e.g. register-file read ports, peripheral streams) and one shared consumer.

Parameters:
- N, 4, number of input channels (N >= 1).
- W, 32, data width per channel.
- MODE, ARB_RR, arbitration mode from mux_pkg::arb_mode_t: ARB_RR = round-robin, ARB_FIXED = lowest index wins.
- SEL_W, (N > 1) ? $clog2(N) : 1, width of the channel index (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; one-hot or zero.
- in_data  input  N*W  flattened inputs; channel i occupies in_data[i*W +: W].
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer ready.
- out_data  output  W  selected word.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_sel=0, RR pointer ptr=0.
  - in_ready=0 while reset is asserted.
  - A word held in the output register is discarded.
- Load condition: load = !out_valid || out_ready, meaning the output register is empty or is draining this cycle.
- Winner selection (combinational):
  - ARB_RR: first asserted in_valid found scanning ptr, ptr+1, … N-1, 0, … ptr-1.
  - ARB_FIXED: lowest asserted index.
- in_ready[i] = load && any_valid && (winner == i). Never more than one bit is set.
- in_ready must not depend on in_data. It may depend combinationally on in_valid and out_ready.
- Clock edge with load && any_valid:
  - out_data <= in_data[winner], out_sel <= winner, out_valid <= 1.
  - ARB_RR only: ptr <= (winner == N-1) ? 0 : winner+1.
- Clock edge with load && !any_valid: out_valid <= 0. out_data and out_sel hold their previous values (don't-care).
- Clock edge with !load: all registers hold. out_data and out_sel are stable while out_valid=1 && out_ready=0.
- Latency and throughput:
  - Latency is 1 cycle from an accepted input to out_valid.
  - Throughput is 1 word/cycle when out_ready=1.
- Simultaneous drain and fill in one cycle (out_valid=1, out_ready=1, some in_valid=1): the next word loads with no bubble.
- ptr only advances on an actual grant. An idle cycle leaves ptr unchanged.
- N=1: the arbiter degenerates to a registered pipe stage. out_sel=0 always, ptr constant 0.
- N not a power of two: ptr wraps from N-1 to 0 and never holds an index ≥ N.
- A channel that drops in_valid before it is granted loses nothing. The arbiter does not latch requests.

Decomposition:
- mux_pkg:
  - typedef enum {ARB_RR, ARB_FIXED} arb_mode_t.
  - Function clog2_min1 for SEL_W.
- Sub-module rr_picker (combinational), parametrised by N and MODE:
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: grant one-hot [N], grant_idx [SEL_W], any.
  - Implementation: double-width rotate-and-priority-encode.
- rr_mux_stream holds the output register, ptr register and handshake logic.

Test Plan (N=4, W=32, channel i data = 32'd(i) unless noted):
1. Reset: rst=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately, without waiting for a clock. After release with all in_valid=1 and out_ready=1, the first output has out_sel=0.
2. Single requester: in_valid=4'b0100, in_data ch2=32'hDEAD_0002, out_ready=1 -> in_ready=4'b0100 in that cycle. Next cycle out_valid=1, out_data=32'hDEAD_0002, out_sel=2.
3. RR fairness: MODE=ARB_RR, in_valid=4'b1111 held, out_ready=1 for 9 cycles -> out_sel sequence 0,1,2,3,0,1,2,3,0 with out_valid=1 every cycle and no bubbles.
4. Backpressure: out_valid=1 with out_sel=1, then out_ready=0 for 5 cycles -> out_data=1 and out_sel=1 stable, in_ready=4'b0000 throughout. Raise out_ready with in_valid=4'b1111 -> next out_sel=2.
5. Fixed priority plus skip: MODE=ARB_FIXED, in_valid=4'b1010 -> out_sel=1 every cycle, in_ready[3] never 1. Same stimulus with ARB_RR from ptr=2 -> out_sel alternates 3,1,3,1.
6. Idle and wrap: ARB_RR, grant ch3 (in_valid=4'b1000), then in_valid=0 for 3 cycles -> out_valid=0 after one cycle and ptr stays 0. Then in_valid=4'b1001 -> out_sel=0 first, then 3.
